rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline write-back (WB) path;
  - a variable-latency memory load-return path.
- Holds a one-entry buffer for load returns and keeps a per-register pending-load scoreboard.
- Reports source/destination hazards from the scoreboard to the hazard detection unit.
- Requests a pipeline stall when a buffered load has been starved of the write port for too long.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register index width; scoreboard has 2**ADDR_W entries
- STARVE_LIMIT, 4, consecutive cycles a buffered load may lose arbitration before stall_req asserts (1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- wb_valid  in  1  WB stage has a register write this cycle; never back-pressured
- wb_dest  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB result
- ld_issue  in  1  load issued to memory this cycle; marks ld_dest pending
- ld_dest  in  ADDR_W  destination of the issued load
- mem_valid  in  1  load-return beat offered
- mem_ready  out  1  load-return beat accepted this cycle when mem_valid && mem_ready
- mem_dest  in  ADDR_W  load-return destination
- mem_data  in  DATA_W  load-return data
- rf_we  out  1  register file write enable
- rf_dest  out  ADDR_W  register file write address
- rf_data  out  DATA_W  register file write data
- src1  in  ADDR_W  decode-stage source 1
- src2  in  ADDR_W  decode-stage source 2
- dest  in  ADDR_W  decode-stage destination
- two_src  in  1  src2 is a real operand
- pending  out  2**ADDR_W  scoreboard bit vector
- ld_hazard  out  1  decode instruction touches a pending register
- stall_req  out  1  request for the pipeline to insert a bubble at WB

Behaviour:
- Reset (rst=0, asynchronous):
  - hold_valid=0, pending=0, starve counter=0, stall_req=0.
  - Resulting combinational outputs: mem_ready=1, rf_we=0, ld_hazard=0.
- Holding register (hold_valid, hold_dest, hold_data):
  - Captures a beat on mem_valid && mem_ready.
  - Write to the RF: earliest the cycle after acceptance; no combinational path from mem_* to rf_*.
- Write-port arbitration (combinational, fixed priority):
  - wb_valid=1: rf_we=1, rf_dest=wb_dest, rf_data=wb_data; the held entry waits.
  - else hold_valid=1: rf_we=1, rf_dest=hold_dest, rf_data=hold_data; the entry drains (hold_valid clears at the edge).
  - else rf_we=0; rf_dest/rf_data are don't-care and are driven 0.
- mem_ready = !hold_valid || drain. A same-cycle drain plus accept refills the holding register; throughput is 1 beat/cycle when wb_valid=0.
- Scoreboard, per register r, each edge:
  - set if ld_issue && ld_dest==r;
  - clear if a drain writes r;
  - simultaneous set and clear of the same r: set wins, bit stays 1.
  - The hazard unit guarantees at most one outstanding load per register.
- Hazard output: ld_hazard = pending[src1] | (two_src & pending[src2]) | pending[dest]. The dest term blocks write-after-write ordering against WB.
- Starvation state machine:
  - IDLE: hold_valid=0 or the entry drains this cycle; counter=0.
  - WAIT: hold_valid && wb_valid; counter increments, saturating at STARVE_LIMIT.
  - STALL: counter==STARVE_LIMIT; stall_req=1 (registered). Stays asserted until the drain cycle, deasserts the cycle after the drain.
- Robustness:
  - mem_valid without a matching pending bit is accepted and written normally; the scoreboard is unaffected except for the clear.
  - Reset mid-operation discards the held entry and all pending bits.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined — adds these outputs:
  - byp_hit1 / byp_hit2 (1 bit): rf_we && rf_dest==src1 / src2 in the same cycle.
  - byp_data1 / byp_data2 (DATA_W): rf_data.
  - With a hit, ld_hazard ignores the pending bit of the matching source, letting decode consume a load result in its write-back cycle.
- Not defined: these ports are absent and ld_hazard follows the base equation.

Test Plan:
1. Reset with mem_valid=1 → rf_we=0, pending=0, mem_ready=1. After rst deasserts with wb_valid=0, a beat (dest 5, data 0xDEADBEEF) is accepted; the next cycle rf_we=1, rf_dest=5, rf_data=0xDEADBEEF.
2. ld_issue dest 3 → pending[3]=1 and ld_hazard=1 for src1=3. Return dest 3 while wb_valid=0 → pending[3] clears the cycle after the write.
3. Collision: a held beat (dest 7) while wb_valid=1 (dest 2, 0x11) → the RF sees dest 2 first; mem_ready=0 while held; dest 7 is written the first cycle wb_valid=0.
4. Starvation: wb_valid held 1 with an entry held, STARVE_LIMIT=4 → stall_req=1 after 4 waiting cycles. Drop wb_valid → drain, then stall_req=0 the next cycle.
5. Same-cycle ld_issue dest 4 and drain of dest 4 → pending[4]=1 afterwards. Back-to-back returns with wb_valid=0 → one write per cycle, mem_ready stays 1.
6. Assert rst mid-hold (hold_valid=1, pending=0x0080) → immediately hold_valid=0, pending=0, stall_req=0, rf_we=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between the in-order write-back
// path (always wins) and a one-entry buffered memory load-return path. It also
// keeps a per-register pending-load scoreboard, reports decode hazards from it,
// and requests a pipeline stall when a buffered load is starved too long.
//
// Optional feature, macro RF_WR_BYPASS_EN: adds same-cycle forwarding outputs
// (byp_hit1/2, byp_data1/2). When a decode source is being written this cycle,
// its pending bit is masked out of ld_hazard.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // write-back requester
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_dest,
  input  logic [DATA_W-1:0]      wb_data,
  // load issue tracking
  input  logic                   ld_issue,
  input  logic [ADDR_W-1:0]      ld_dest,
  // load-return requester
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_dest,
  input  logic [DATA_W-1:0]      mem_data,
  // register file write port
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_dest,
  output logic [DATA_W-1:0]      rf_data,
  // decode-stage hazard query
  input  logic [ADDR_W-1:0]      src1,
  input  logic [ADDR_W-1:0]      src2,
  input  logic [ADDR_W-1:0]      dest,
  input  logic                   two_src,
  output logic [(2**ADDR_W)-1:0] pending,
`ifdef RF_WR_BYPASS_EN
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [DATA_W-1:0]      byp_data1,
  output logic [DATA_W-1:0]      byp_data2,
`endif
  output logic                   ld_hazard,
  output logic                   stall_req
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Starvation tracker states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // Saturating increment of the starvation counter; never exceeds LIMIT.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v >= LIMIT) return LIMIT;
    else            return v + 1'b1;
  endfunction

  // One-hot decode of a register index into a scoreboard mask.
  function automatic logic [NREG-1:0] regMask(input logic [ADDR_W-1:0] idx);
    logic [NREG-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Holding register: load-return stage p1
  logic              vld_p1;
  logic [ADDR_W-1:0] holdDest_p1;
  logic [DATA_W-1:0] holdData_p1;

  logic              drain;
  logic              accept;
  logic [NREG-1:0]   pendingQ;
  logic [NREG-1:0]   setMask;
  logic [NREG-1:0]   clrMask;

  logic [CNT_W-1:0]  starveCnt;
  logic [CNT_W-1:0]  starveCntNext;
  logic [1:0]        starveState;
  logic [1:0]        starveStateNext;

  logic              hazSrc1;
  logic              hazSrc2;

  // The held entry only gets the port when write-back is idle.
  assign drain     = vld_p1 && !wb_valid;
  assign mem_ready = !vld_p1 || drain;
  assign accept    = mem_valid && mem_ready;

  // Holding-register occupancy: refill on accept, empty on a drain without refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  // Holding-register payload; qualified by vld_p1 so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      holdDest_p1 <= mem_dest;
      holdData_p1 <= mem_data;
    end
  end

  // Write-port mux: write-back has fixed priority over the held load.
  always_comb begin
    rf_we   = 1'b0;
    rf_dest = '0;
    rf_data = '0;
    if (wb_valid) begin
      rf_we   = 1'b1;
      rf_dest = wb_dest;
      rf_data = wb_data;
    end else if (vld_p1) begin
      rf_we   = 1'b1;
      rf_dest = holdDest_p1;
      rf_data = holdData_p1;
    end
  end

  // Scoreboard masks: a load issue sets, a drain clears; set is applied last.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (ld_issue) setMask = regMask(ld_dest);
    if (drain)    clrMask = regMask(holdDest_p1);
  end

  // Pending-load scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendingQ <= '0;
    end else begin
      pendingQ <= (pendingQ & ~clrMask) | setMask;
    end
  end

  assign pending = pendingQ;

`ifdef RF_WR_BYPASS_EN
  assign byp_hit1  = rf_we && (rf_dest == src1);
  assign byp_hit2  = rf_we && (rf_dest == src2);
  assign byp_data1 = rf_data;
  assign byp_data2 = rf_data;
  assign hazSrc1   = pendingQ[src1] && !byp_hit1;
  assign hazSrc2   = two_src && pendingQ[src2] && !byp_hit2;
`else
  assign hazSrc1   = pendingQ[src1];
  assign hazSrc2   = two_src && pendingQ[src2];
`endif

  // The dest term keeps a younger WB write from overtaking an outstanding load.
  assign ld_hazard = hazSrc1 || hazSrc2 || pendingQ[dest];

  // Starvation next-state: count cycles the held entry loses to write-back.
  always_comb begin
    starveStateNext = starveState;
    starveCntNext   = starveCnt;
    if (!vld_p1 || drain) begin
      starveStateNext = ST_IDLE;
      starveCntNext   = '0;
    end else begin
      case (starveState)
        ST_IDLE, ST_WAIT: begin
          starveCntNext   = satInc(starveCnt);
          starveStateNext = (satInc(starveCnt) == LIMIT) ? ST_STALL : ST_WAIT;
        end
        ST_STALL: begin
          starveCntNext   = LIMIT;
          starveStateNext = ST_STALL;
        end
        default: begin
          starveStateNext = ST_IDLE;
          starveCntNext   = '0;
        end
      endcase
    end
  end

  // Starvation state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveState <= ST_IDLE;
      starveCnt   <= '0;
    end else begin
      starveState <= starveStateNext;
      starveCnt   <= starveCntNext;
    end
  end

  // stall_req comes straight from the state register, so it is glitch-free
  // and drops the cycle after the drain.
  assign stall_req = (starveState == ST_STALL);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected RF writes are queued when
// stimulus is issued and a negedge monitor pops/compares every rf_we cycle.
module tb_rf_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_dest;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] src1, src2, dest;
  logic              two_src;
  logic [15:0]       pending;
  logic              ld_hazard;
  logic              stall_req;
`ifdef RF_WR_BYPASS_EN
  logic              byp_hit1, byp_hit2;
  logic [DATA_W-1:0] byp_data1, byp_data2;
`endif

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] expQ[$];

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_dest(ld_dest),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
    .src1(src1), .src2(src2), .dest(dest), .two_src(two_src),
    .pending(pending),
`ifdef RF_WR_BYPASS_EN
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
    .ld_hazard(ld_hazard), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    expQ.push_back({d, v});
  endtask

  // Monitor: every RF write must match the next queued expectation.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst === 1'b1 && rf_we === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got dest %0d data 0x%0h, expected no write", rf_dest, rf_data);
      end else begin
        e = expQ.pop_front();
        if ({rf_dest, rf_data} !== e) begin
          errors++;
          $display("FAIL rf_write: got dest %0d data 0x%0h, expected dest %0d data 0x%0h",
                   rf_dest, rf_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
    ld_issue = 1'b0; ld_dest = '0;
    mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 32'hDEADBEEF;
    src1 = '0; src2 = '0; dest = '0; two_src = 1'b0;

    // 1. reset with a beat offered, then first acceptance
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_pending", pending, 0);
    chk("reset_mem_ready", mem_ready, 1);
    chk("reset_stall", stall_req, 0);
    chk("reset_hazard", ld_hazard, 0);
    step(); rst = 1'b1; push(4'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("no_comb_path_rf_we", rf_we, 0);
    chk("accept_mem_ready", mem_ready, 1);
    step(); mem_valid = 1'b0;
    @(negedge clk);
    chk("drain_mem_ready", mem_ready, 1);

    // 2. scoreboard set, hazard terms, clear after return
    step(); ld_issue = 1'b1; ld_dest = 4'd3; src1 = 4'd3;
    step(); ld_issue = 1'b0;
    @(negedge clk);
    chk("pending3_set", pending, 16'h0008);
    chk("hazard_src1", ld_hazard, 1);
    #1 src1 = 4'd0; src2 = 4'd3; two_src = 1'b0;
    #1 chk("hazard_src2_unused", ld_hazard, 0);
    two_src = 1'b1;
    #1 chk("hazard_src2_used", ld_hazard, 1);
    two_src = 1'b0; dest = 4'd3;
    #1 chk("hazard_dest", ld_hazard, 1);
    dest = 4'd0; src1 = 4'd3;
    step(); mem_valid = 1'b1; mem_dest = 4'd3; mem_data = 32'h33333333; push(4'd3, 32'h33333333);
    step(); mem_valid = 1'b0;
    @(negedge clk);
    chk("pending3_during_write", pending, 16'h0008);
    step();
    @(negedge clk);
    chk("pending3_cleared", pending, 16'h0000);
    chk("hazard_cleared", ld_hazard, 0);
    src1 = 4'd0;

    // 3. collision: WB wins, held beat waits
    step(); mem_valid = 1'b1; mem_dest = 4'd7; mem_data = 32'h00000077;
    push(4'd2, 32'h00000011); push(4'd7, 32'h00000077);
    step(); mem_valid = 1'b0; wb_valid = 1'b1; wb_dest = 4'd2; wb_data = 32'h11;
    @(negedge clk);
    chk("collision_mem_ready", mem_ready, 0);
    step(); wb_valid = 1'b0;
    @(negedge clk);
    chk("collision_drain_ready", mem_ready, 1);

    // 4. starvation with STARVE_LIMIT=4
    step(); mem_valid = 1'b1; mem_dest = 4'd9; mem_data = 32'h99;
    for (int k = 1; k <= 6; k++) begin
      step(); mem_valid = 1'b0; wb_valid = 1'b1; wb_dest = 4'(k); wb_data = 32'hA0 + k;
      push(4'(k), 32'hA0 + k);
      @(negedge clk);
      chk($sformatf("starve_cycle%0d", k), stall_req, (k >= 5) ? 1 : 0);
    end
    step(); wb_valid = 1'b0; push(4'd9, 32'h99);
    @(negedge clk);
    chk("stall_held_in_drain", stall_req, 1);
    step();
    @(negedge clk);
    chk("stall_released", stall_req, 0);

    // 5. set wins over same-cycle clear; back-to-back returns
    step(); mem_valid = 1'b1; mem_dest = 4'd4; mem_data = 32'h44; push(4'd4, 32'h44);
    step(); mem_valid = 1'b0; ld_issue = 1'b1; ld_dest = 4'd4;
    step(); ld_issue = 1'b0;
    @(negedge clk);
    chk("set_wins_pending4", pending, 16'h0010);
    step(); mem_valid = 1'b1; mem_dest = 4'd4; mem_data = 32'h4A; push(4'd4, 32'h4A);
    @(negedge clk); chk("b2b_ready1", mem_ready, 1);
    step(); mem_dest = 4'd6; mem_data = 32'h6B; push(4'd6, 32'h6B);
    @(negedge clk); chk("b2b_ready2", mem_ready, 1);
    step(); mem_dest = 4'd8; mem_data = 32'h8C; push(4'd8, 32'h8C);
    @(negedge clk); chk("b2b_ready3", mem_ready, 1);
    step(); mem_valid = 1'b0;
    step();
    @(negedge clk);
    chk("b2b_pending_clear", pending, 16'h0000);

    // 6. asynchronous reset while an entry is held
    step(); ld_issue = 1'b1; ld_dest = 4'd7;
    mem_valid = 1'b1; mem_dest = 4'd12; mem_data = 32'hC;
    wb_valid = 1'b1; wb_dest = 4'd1; wb_data = 32'h1; push(4'd1, 32'h1);
    step(); ld_issue = 1'b0; mem_valid = 1'b0; wb_dest = 4'd2; wb_data = 32'h2; push(4'd2, 32'h2);
    @(negedge clk);
    chk("prereset_pending", pending, 16'h0080);
    chk("prereset_held", mem_ready, 0);
    #1 rst = 1'b0; wb_valid = 1'b0;
    #1;
    chk("async_reset_pending", pending, 0);
    chk("async_reset_hold", mem_ready, 1);
    chk("async_reset_stall", stall_req, 0);
    chk("async_reset_rf_we", rf_we, 0);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    chk("scoreboard_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
